// File: rtl/ilf_pkg.sv
// Shared types and sizes for the instruction line fetch unit.
// Holds the FSM state enum and line/beat geometry.
package ilf_pkg;

    localparam int LINE_BEATS      = 8;
    localparam int BEAT_W          = 64;
    localparam int LINE_W          = 512;
    localparam int INDEX_W         = 19;
    localparam int ILF_TIMEOUT_MAX = 1023;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        REQ,
        RECV,
        OUT,
        DONE,
        DRAIN
    } ilf_state_t;

endpackage

// File: rtl/ilf_if.sv
// PC / DDR / instruction-buffer bundle of the line fetch unit.
// timeout_err exists only when ILF_TIMEOUT_EN is defined.
interface ilf_if;
    import ilf_pkg::*;

    logic               pc_index_valid;
    logic [INDEX_W-1:0] pc_index;
    logic               flush;
    logic               pc_index_done;
    logic               ddr_chip_enable;
    logic [INDEX_W-1:0] ddr_index;
    logic               ddr_ready;
    logic [BEAT_W-1:0]  ddr_rdata;
    logic               ddr_rdata_valid;
    logic               line_valid;
    logic [LINE_W-1:0]  line_data;
    logic               line_ready;
`ifdef ILF_TIMEOUT_EN
    logic               timeout_err;
`endif

    modport master (
        input  pc_index_valid,
        input  pc_index,
        input  flush,
        output pc_index_done,
        output ddr_chip_enable,
        output ddr_index,
        input  ddr_ready,
        input  ddr_rdata,
        input  ddr_rdata_valid,
        output line_valid,
        output line_data,
        input  line_ready
`ifdef ILF_TIMEOUT_EN
        ,
        output timeout_err
`endif
    );

    modport slave (
        output pc_index_valid,
        output pc_index,
        output flush,
        input  pc_index_done,
        input  ddr_chip_enable,
        input  ddr_index,
        output ddr_ready,
        output ddr_rdata,
        output ddr_rdata_valid,
        input  line_valid,
        input  line_data,
        output line_ready
`ifdef ILF_TIMEOUT_EN
        ,
        input  timeout_err
`endif
    );

endinterface

// File: rtl/ilf_line_assembler.sv
// Collects eight 64-bit DDR beats into one 512-bit line.
// The counter saturates at the last slot; full blocks further writes.
module ilf_line_assembler
    import ilf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              beat_valid,
    input  logic [BEAT_W-1:0] beat_data,
    output logic              full,
    output logic [LINE_W-1:0] line
);

    logic [2:0]        cnt_q;
    logic              full_q;
    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
            line_q <= '0;
        end else if (clear) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else if (beat_valid && !full_q) begin
            line_q[{cnt_q, 6'd0} +: BEAT_W] <= beat_data;
            if (cnt_q == 3'd7) begin
                full_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    assign full = full_q;
    assign line = line_q;

endmodule

// File: rtl/inst_line_fetch.sv
// Fetches one 64-byte instruction line from DDR for the PC stage.
// Define ILF_TIMEOUT_EN to add the 1023-cycle DDR timeout.
module inst_line_fetch
    import ilf_pkg::*;
(
    input logic   clk,
    input logic   rst_n,
    ilf_if.master bus
);

    ilf_state_t         state_q;
    ilf_state_t         state_d;
    logic [INDEX_W-1:0] index_q;
    logic [3:0]         seen_q;
    logic               beat;
    logic               drain_end;
    logic               tmo_hit;
    logic               asm_clear;
    logic               asm_beat;
    logic               asm_full;
    logic [LINE_W-1:0]  asm_line;
    logic               chip_enable;
    logic               lvalid;
    logic               done;

    assign beat = bus.ddr_rdata_valid
                && (state_q == RECV || state_q == DRAIN);

    // Beats still owed by DDR after a flush are counted off here.
    assign drain_end = (seen_q == 4'(LINE_BEATS))
                     || (bus.ddr_rdata_valid
                         && seen_q == 4'(LINE_BEATS - 1));

`ifdef ILF_TIMEOUT_EN
    logic       busy;
    logic [9:0] tmo_q;

    assign busy = state_q == REQ || state_q == RECV
               || state_q == DRAIN;
    assign tmo_hit = busy
                  && (tmo_q == 10'(ILF_TIMEOUT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (!busy || beat) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 10'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= '0;
            seen_q  <= '0;
        end else begin
            if (state_q == SETTLE) begin
                index_q <= bus.pc_index;
            end
            if (state_q == REQ) begin
                seen_q <= '0;
            end else if (beat && seen_q != 4'(LINE_BEATS)) begin
                seen_q <= seen_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.pc_index_valid && !bus.flush) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (bus.flush || !bus.pc_index_valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.flush) begin
                    state_d = bus.ddr_ready ? DRAIN : IDLE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end else if (bus.ddr_ready) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (bus.flush) begin
                    state_d = DRAIN;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end else if (asm_full) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.line_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            DRAIN: begin
                if (tmo_hit || drain_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        chip_enable = 1'b0;
        lvalid      = 1'b0;
        done        = 1'b0;
        asm_clear   = 1'b0;
        asm_beat    = 1'b0;
        chip_enable = state_q == REQ;
        lvalid      = state_q == OUT;
        done        = state_q == DONE;
        asm_clear   = state_q == REQ;
        asm_beat    = bus.ddr_rdata_valid && state_q == RECV;
    end

    assign bus.ddr_chip_enable = chip_enable;
    assign bus.line_valid      = lvalid;
    assign bus.pc_index_done   = done;
    assign bus.ddr_index       = index_q;
    assign bus.line_data       = asm_line;
`ifdef ILF_TIMEOUT_EN
    assign bus.timeout_err     = tmo_hit;
`endif

    ilf_line_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .beat_valid (asm_beat),
        .beat_data  (bus.ddr_rdata),
        .full       (asm_full),
        .line       (asm_line)
    );

endmodule

// File: tb/tb_inst_line_fetch.sv
// Directed self-checking bench for inst_line_fetch.
// Covers ILF_TIMEOUT_EN when that macro is defined.
module tb_inst_line_fetch;
    import ilf_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   lv_cnt = 0;

    ilf_if bus ();

    inst_line_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.pc_index_done) done_cnt++;
        if (bus.line_valid) lv_cnt++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.pc_index_valid  = 1'b0;
        bus.pc_index        = '0;
        bus.flush           = 1'b0;
        bus.ddr_ready       = 1'b0;
        bus.ddr_rdata       = '0;
        bus.ddr_rdata_valid = 1'b0;
        bus.line_ready      = 1'b0;
    endtask

    task automatic start_req(input logic [INDEX_W-1:0] idx);
        bus.pc_index       = idx;
        bus.pc_index_valid = 1'b1;
    endtask

    task automatic send_beats(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            bus.ddr_rdata_valid = 1'b1;
            bus.ddr_rdata       = base + 64'(i);
            tick();
        end
        bus.ddr_rdata_valid = 1'b0;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.ddr_chip_enable;
            1:       return bus.line_valid;
            2:       return bus.pc_index_done;
`ifdef ILF_TIMEOUT_EN
            3:       return bus.timeout_err;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int max,
                            output int cyc);
        cyc = 0;
        while (!sig(sel) && cyc < max) begin
            tick();
            cyc++;
        end
        if (!sig(sel)) cyc = -1;
    endtask

    function automatic logic [LINE_W-1:0] mk_line(
        input logic [63:0] base);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int k = 0; k < LINE_BEATS; k++)
            l[64*k +: 64] = base + 64'(k);
        return l;
    endfunction

    task automatic to_out(input logic [63:0] base, output bit ok);
        int c;
        ok = 1'b1;
        wait_sig(0, 50, c);
        if (c < 0) ok = 1'b0;
        bus.ddr_ready = 1'b1;
        tick();
        bus.ddr_ready = 1'b0;
        send_beats(8, base);
        wait_sig(1, 50, c);
        if (c < 0) ok = 1'b0;
    endtask

    task automatic accept(output bit ok);
        int c;
        bus.line_ready = 1'b1;
        tick();
        bus.line_ready = 1'b0;
        wait_sig(2, 10, c);
        ok = (c >= 0);
        bus.pc_index_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.ddr_chip_enable !== 1'b0 || bus.line_valid !== 1'b0
            || bus.pc_index_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: ce=%b lv=%b done=%b want 0",
                     bus.ddr_chip_enable, bus.line_valid,
                     bus.pc_index_done);
        end
        checks++;
        if (bus.ddr_index !== '0) begin
            errors++;
            $display("FAIL reset_index: got %h want 0", bus.ddr_index);
        end
        checks++;
        if (bus.line_data !== '0) begin
            errors++;
            $display("FAIL reset_line: got %h want 0", bus.line_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_cnt;
        bus.line_ready = 1'b0;
        start_req(19'h00040);
        tick();
        checks++;
        if (bus.ddr_chip_enable !== 1'b0) begin
            errors++;
            $display("FAIL basic_settle_ce: got %b want 0",
                     bus.ddr_chip_enable);
        end
        tick();
        checks++;
        if (bus.ddr_chip_enable !== 1'b1) begin
            errors++;
            $display("FAIL basic_req_ce: got %b want 1",
                     bus.ddr_chip_enable);
        end
        checks++;
        if (bus.ddr_index !== 19'h00040) begin
            errors++;
            $display("FAIL basic_index: got %h want 00040",
                     bus.ddr_index);
        end
        tick();
        bus.ddr_ready = 1'b1;
        tick();
        bus.ddr_ready = 1'b0;
        checks++;
        if (bus.ddr_chip_enable !== 1'b0) begin
            errors++;
            $display("FAIL basic_ce_drop: got %b want 0",
                     bus.ddr_chip_enable);
        end
        send_beats(8, 64'h0);
        checks++;
        if (bus.line_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_lv_early: got %b want 0",
                     bus.line_valid);
        end
        tick();
        checks++;
        if (bus.line_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_lv_latency: got %b want 1",
                     bus.line_valid);
        end
        checks++;
        if (bus.line_data !== mk_line(64'h0)) begin
            errors++;
            $display("FAIL basic_line: got %h want %h",
                     bus.line_data, mk_line(64'h0));
        end
        bus.line_ready = 1'b1;
        tick();
        bus.line_ready = 1'b0;
        bus.pc_index_valid = 1'b0;
        checks++;
        if (bus.pc_index_done !== 1'b1 || bus.line_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b lv=%b want 1/0",
                     bus.pc_index_done, bus.line_valid);
        end
        tick();
        tick();
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL basic_done_pulses: got %0d want 1",
                     done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        logic [LINE_W-1:0] exp;
        bit ok;
        bit stable;
        int d0;
        exp = mk_line(64'h100);
        d0 = done_cnt;
        start_req(19'h12345);
        to_out(64'h100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_reach_out: got 0 want 1");
        end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.line_valid !== 1'b1 || bus.line_data !== exp)
                stable = 1'b0;
            tick();
        end
        checks++;
        if (!stable || bus.line_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stable: lv=%b line=%h want 1/%h",
                     bus.line_valid, bus.line_data, exp);
        end
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL bp_early_done: got %0d want %0d",
                     done_cnt, d0);
        end
        accept(ok);
        checks++;
        if (!ok || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL bp_done: got %0d pulses want 1",
                     done_cnt - d0);
        end
    endtask

    task automatic test_flush_recv();
        bit ok;
        int d0;
        int l0;
        int c;
        d0 = done_cnt;
        l0 = lv_cnt;
        start_req(19'h00100);
        wait_sig(0, 20, c);
        bus.ddr_ready = 1'b1;
        tick();
        bus.ddr_ready = 1'b0;
        send_beats(3, 64'hA0);
        bus.flush = 1'b1;
        bus.pc_index_valid = 1'b0;
        tick();
        bus.flush = 1'b0;
        start_req(19'h00200);
        send_beats(4, 64'hB0);
        checks++;
        if (bus.ddr_chip_enable !== 1'b0) begin
            errors++;
            $display("FAIL fr_drain4_ce: got %b want 0",
                     bus.ddr_chip_enable);
        end
        tick();
        tick();
        checks++;
        if (bus.ddr_chip_enable !== 1'b0) begin
            errors++;
            $display("FAIL fr_drain_wait: got %b want 0",
                     bus.ddr_chip_enable);
        end
        send_beats(1, 64'hB4);
        tick();
        tick();
        checks++;
        if (bus.ddr_chip_enable !== 1'b1
            || bus.ddr_index !== 19'h00200) begin
            errors++;
            $display("FAIL fr_next_req: ce=%b idx=%h want 1/00200",
                     bus.ddr_chip_enable, bus.ddr_index);
        end
        checks++;
        if (lv_cnt !== l0 || done_cnt !== d0) begin
            errors++;
            $display("FAIL fr_no_line: lv=%0d done=%0d want 0/0",
                     lv_cnt - l0, done_cnt - d0);
        end
        to_out(64'h300, ok);
        checks++;
        if (!ok || bus.line_data !== mk_line(64'h300)) begin
            errors++;
            $display("FAIL fr_next_line: got %h want %h",
                     bus.line_data, mk_line(64'h300));
        end
        accept(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fr_next_done: got 0 want 1");
        end
    endtask

    task automatic test_flush_ready();
        bit ok;
        int c;
        int d0;
        d0 = done_cnt;
        start_req(19'h00300);
        wait_sig(0, 20, c);
        bus.ddr_ready = 1'b1;
        bus.flush = 1'b1;
        bus.pc_index_valid = 1'b0;
        tick();
        bus.ddr_ready = 1'b0;
        bus.flush = 1'b0;
        send_beats(7, 64'hC0);
        start_req(19'h00400);
        tick();
        tick();
        checks++;
        if (bus.ddr_chip_enable !== 1'b0) begin
            errors++;
            $display("FAIL fy_drain7_ce: got %b want 0",
                     bus.ddr_chip_enable);
        end
        send_beats(1, 64'hC7);
        tick();
        tick();
        checks++;
        if (bus.ddr_chip_enable !== 1'b1
            || bus.ddr_index !== 19'h00400) begin
            errors++;
            $display("FAIL fy_next_req: ce=%b idx=%h want 1/00400",
                     bus.ddr_chip_enable, bus.ddr_index);
        end
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL fy_no_done: got %0d want 0",
                     done_cnt - d0);
        end
        to_out(64'h500, ok);
        checks++;
        if (!ok || bus.line_data !== mk_line(64'h500)) begin
            errors++;
            $display("FAIL fy_next_line: got %h want %h",
                     bus.line_data, mk_line(64'h500));
        end
        accept(ok);
    endtask

    task automatic test_flush_misc();
        bit ok;
        int c;
        int d0;
        d0 = done_cnt;
        start_req(19'h00500);
        tick();
        bus.flush = 1'b1;
        bus.pc_index_valid = 1'b0;
        tick();
        bus.flush = 1'b0;
        tick();
        checks++;
        if (bus.ddr_chip_enable !== 1'b0) begin
            errors++;
            $display("FAIL fm_settle_flush: got %b want 0",
                     bus.ddr_chip_enable);
        end
        start_req(19'h00600);
        wait_sig(0, 20, c);
        bus.flush = 1'b1;
        bus.pc_index_valid = 1'b0;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.ddr_chip_enable !== 1'b0) begin
            errors++;
            $display("FAIL fm_req_flush: got %b want 0",
                     bus.ddr_chip_enable);
        end
        send_beats(3, 64'hBAD0);
        checks++;
        if (bus.ddr_chip_enable !== 1'b0 || bus.line_valid !== 1'b0) begin
            errors++;
            $display("FAIL fm_stray_beats: ce=%b lv=%b want 0/0",
                     bus.ddr_chip_enable, bus.line_valid);
        end
        start_req(19'h00700);
        to_out(64'h700, ok);
        checks++;
        if (!ok || bus.line_data !== mk_line(64'h700)) begin
            errors++;
            $display("FAIL fm_line: got %h want %h",
                     bus.line_data, mk_line(64'h700));
        end
        bus.line_ready = 1'b1;
        bus.flush = 1'b1;
        bus.pc_index_valid = 1'b0;
        tick();
        bus.line_ready = 1'b0;
        bus.flush = 1'b0;
        checks++;
        if (bus.line_valid !== 1'b0 || bus.pc_index_done !== 1'b0) begin
            errors++;
            $display("FAIL fm_out_flush: lv=%b done=%b want 0/0",
                     bus.line_valid, bus.pc_index_done);
        end
        tick();
        tick();
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL fm_no_done: got %0d want 0",
                     done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int c;
        start_req(19'h00800);
        wait_sig(0, 20, c);
        bus.ddr_ready = 1'b1;
        tick();
        bus.ddr_ready = 1'b0;
        send_beats(3, 64'hE0);
        bus.ddr_rdata_valid = 1'b1;
        bus.ddr_rdata = 64'hE3;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ddr_chip_enable !== 1'b0 || bus.line_valid !== 1'b0
            || bus.pc_index_done !== 1'b0
            || bus.ddr_index !== '0) begin
            errors++;
            $display("FAIL rm_async_ctl: ce=%b lv=%b dn=%b idx=%h",
                     bus.ddr_chip_enable, bus.line_valid,
                     bus.pc_index_done, bus.ddr_index);
        end
        checks++;
        if (bus.line_data !== '0) begin
            errors++;
            $display("FAIL rm_async_line: got %h want 0",
                     bus.line_data);
        end
        tick();
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        start_req(19'h7FFF8);
        to_out(64'hF00D_0000_0000_0000, ok);
        checks++;
        if (!ok || bus.line_data
                   !== mk_line(64'hF00D_0000_0000_0000)) begin
            errors++;
            $display("FAIL rm_line: got %h want %h", bus.line_data,
                     mk_line(64'hF00D_0000_0000_0000));
        end
        checks++;
        if (bus.ddr_index !== 19'h7FFF8) begin
            errors++;
            $display("FAIL rm_index: got %h want 7fff8",
                     bus.ddr_index);
        end
        accept(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rm_done: got 0 want 1");
        end
    endtask

`ifdef ILF_TIMEOUT_EN
    task automatic test_timeout();
        int c;
        int n;
        int d0;
        d0 = done_cnt;
        start_req(19'h00055);
        wait_sig(0, 20, c);
        n = 0;
        while (!bus.timeout_err && n < 1100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 1023) begin
            errors++;
            $display("FAIL to_delay: got %0d want 1023", n);
        end
        bus.pc_index_valid = 1'b0;
        tick();
        checks++;
        if (bus.ddr_chip_enable !== 1'b0 || bus.timeout_err !== 1'b0
            || done_cnt !== d0) begin
            errors++;
            $display("FAIL to_idle: ce=%b te=%b done=%0d want 0",
                     bus.ddr_chip_enable, bus.timeout_err,
                     done_cnt - d0);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_backpressure();
        test_flush_recv();
        test_flush_ready();
        test_flush_misc();
        test_reset_mid();
`ifdef ILF_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_line_fetch.md
INST_LINE_FETCH -- requirements
Module: inst_line_fetch

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 pc_index_valid  in  1  fetch request pending from PC stage; level, held until pc_index_done.
REQ-004 pc_index  in  19  start 8-byte word index of the 64-byte line.
REQ-005 flush  in  1  interrupt/redirect; aborts the current fetch.
REQ-006 pc_index_done  out  1  registered one-cycle pulse; line delivered.
REQ-007 ddr_chip_enable  out  1  DDR read request; held until ddr_ready.
REQ-008 ddr_index  out  19  DDR start word index, valid while ddr_chip_enable.
REQ-009 ddr_ready  in  1  DDR accepted request this cycle.
REQ-010 ddr_rdata  in  64  read beat.
REQ-011 ddr_rdata_valid  in  1  ddr_rdata valid; exactly 8 beats per accepted request, in word order.
REQ-012 line_valid  out  1  assembled line available to instruction buffer.
REQ-013 line_data  out  512  line; beat k at bits [64k+63:64k].
REQ-014 line_ready  in  1  instruction buffer accepts line when high with line_valid.
REQ-015 timeout_err  out  1  one-cycle pulse on DDR timeout (present only with ILF_TIMEOUT_EN).

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, REQ, RECV, OUT, DONE, DRAIN.
REQ-017 IDLE->SETTLE when pc_index_valid=1 and flush=0.
REQ-018 SETTLE (one cycle): latch pc_index into ddr_index; ->REQ if pc_index_valid still 1, else IDLE.
REQ-019 REQ: ddr_chip_enable=1; on ddr_ready ->RECV with beat counter=0.
REQ-020 RECV: each ddr_rdata_valid writes ddr_rdata to slot beat counter, counter+1; after 8th beat ->OUT.
REQ-021 Beat counter SHALL be 3 bits plus terminal detect; no wrap-around past 8 beats.
REQ-022 OUT: line_valid=1, line_data stable; on line_ready ->DONE.
REQ-023 DONE (one cycle): pc_index_done=1, line_valid=0; ->IDLE.
REQ-024 Request-to-line latency SHALL be 3 cycles plus DDR latency (SETTLE, REQ, final-beat register).
REQ-025 flush in SETTLE or in REQ without ddr_ready: ->IDLE next cycle, ddr_chip_enable deasserted.
REQ-026 flush in REQ with ddr_ready same cycle, or in RECV: ->DRAIN; DRAIN discards remaining beats (8 minus received) then ->IDLE.
REQ-027 flush in OUT: line dropped, ->IDLE, even if line_ready same cycle.
REQ-028 flush SHALL take priority over every other event; no pc_index_done for a flushed fetch.
REQ-029 New request in DRAIN SHALL wait; IDLE re-evaluates pc_index_valid after drain completes.
REQ-030 ddr_rdata_valid outside RECV/DRAIN SHALL be ignored.

Reset
REQ-031 Reset SHALL force IDLE, beat counter 0, all outputs 0, line_data 0, ddr_index 0.
REQ-032 Reset mid-fetch abandons DDR beats; DDR side is reset by the same rst_n.

Configuration
REQ-033 With ILF_TIMEOUT_EN defined: 10-bit counter cleared on entry to REQ and on each beat, counts in REQ/RECV/DRAIN; at 1023 pulse timeout_err, ->IDLE, no pc_index_done.
REQ-034 Without ILF_TIMEOUT_EN: no counter, no timeout_err port; REQ/RECV/DRAIN wait indefinitely.

Structure
REQ-035 Shared package ilf_pkg SHALL hold state enum, LINE_BEATS=8, BEAT_W=64, LINE_W=512, INDEX_W=19, ILF_TIMEOUT_MAX=1023.
REQ-036 Sub-module ilf_line_assembler SHALL hold beat counter and 8x64 line register (inputs: clear, beat_valid, beat_data; outputs: full, line).

Verification
REQ-037 pc_index_valid=1, pc_index=0x00040, ddr_ready after 2 cycles, beats 0x0..0x7 back-to-back, line_ready=1 -> ddr_index=0x00040, line_data beat k = k, one pc_index_done pulse.
REQ-038 line_ready held 0 for 5 cycles in OUT -> line_valid and line_data stable, pc_index_done only after acceptance.
REQ-039 flush after 3 beats -> DRAIN swallows 5 beats, no line_valid, no pc_index_done, next request fetched correctly.
REQ-040 flush coincident with ddr_ready -> all 8 beats drained, IDLE afterwards.
REQ-041 ILF_TIMEOUT_EN, ddr_ready never asserted -> timeout_err pulse 1023 cycles after REQ entry, FSM IDLE.
REQ-042 rst_n low during RECV beat 4 -> all outputs 0 asynchronously; post-reset fetch of pc_index 0x7FFF8 completes normally.
